// File: rtl/fpu_pkg.sv
// Shared single-precision FPU definitions: rounding modes, flag layout,
// special-operand classes and the divide side-band bundle.
package fpu_pkg;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RDN = 2'b10;
    localparam logic [1:0] RM_RUP = 2'b11;

    localparam int F_NV = 4;
    localparam int F_DZ = 3;
    localparam int F_OF = 2;
    localparam int F_UF = 1;
    localparam int F_NX = 0;

    localparam logic [31:0] QNAN = 32'h7fc00000;
    localparam int          BIAS = 127;

    typedef enum logic [1:0] {
        NORM = 2'd0,
        ZERO = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fclass_t;

    typedef struct packed {
        fclass_t cls;
        logic    nv;
        logic    dz;
    } spec_t;

    typedef struct packed {
        logic       tok;
        logic       s;
        logic [9:0] e;
        logic [1:0] rm;
        spec_t      sp;
    } sb_t;

    // Denormals count as zero; checks run in result-priority order.
    function automatic spec_t classify(input logic [31:0] a,
                                       input logic [31:0] b);
        logic  a_z, b_z, a_i, b_i, a_n, b_n;
        spec_t r;
        a_z = a[30:23] == 8'h00;
        b_z = b[30:23] == 8'h00;
        a_i = (a[30:23] == 8'hff) && (a[22:0] == 23'h0);
        b_i = (b[30:23] == 8'hff) && (b[22:0] == 23'h0);
        a_n = (a[30:23] == 8'hff) && (a[22:0] != 23'h0);
        b_n = (b[30:23] == 8'hff) && (b[22:0] != 23'h0);
        r   = '{cls: NORM, nv: 1'b0, dz: 1'b0};
        if (a_n || b_n) begin
            r.cls = NAN;
            r.nv  = (a_n && !a[22]) || (b_n && !b[22]);
        end else if ((a_i && b_i) || (a_z && b_z)) begin
            r.cls = NAN;
            r.nv  = 1'b1;
        end else if (a_i) begin
            r.cls = INF;
        end else if (b_z) begin
            r.cls = INF;
            r.dz  = 1'b1;
        end else if (a_z || b_i) begin
            r.cls = ZERO;
        end
        return r;
    endfunction

endpackage

// File: rtl/fdiv_round.sv
// Normalize, round and pack the divider E3 quotient into IEEE single,
// with overflow/underflow handling and special-class substitution.
import fpu_pkg::*;

module fdiv_round (
    input  logic [31:0]       q,
    input  logic              s,
    input  logic signed [9:0] e,
    input  logic [1:0]        rm,
    input  fclass_t           cls,
    output logic [31:0]       result,
    output logic [4:0]        flags
);

    logic [23:0]       man;
    logic [24:0]       sum;
    logic [22:0]       frac;
    logic              g;
    logic              st;
    logic              inc;
    logic signed [9:0] ex;
    logic signed [9:0] ef;

    always_comb begin
        if (q[31]) begin
            man = {1'b1, q[30:8]};
            g   = q[7];
            st  = |q[6:0];
            ex  = e + 10'sd1;
        end else begin
            man = {1'b1, q[29:7]};
            g   = q[6];
            st  = |q[5:0];
            ex  = e;
        end
        unique case (rm)
            RM_RNE:  inc = g & (st | man[0]);
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = s & (g | st);
            default: inc = ~s & (g | st);
        endcase
        sum = {1'b0, man} + 25'(inc);
        // A carry out of the mantissa leaves exactly 1.0 at the next binade.
        if (sum[24]) begin
            frac = 23'h0;
            ef   = ex + 10'sd1;
        end else begin
            frac = sum[22:0];
            ef   = ex;
        end
        result = 32'h0;
        flags  = 5'h0;
        unique case (cls)
            NAN:  result = QNAN;
            INF:  result = {s, 8'hff, 23'h0};
            ZERO: result = {s, 31'h0};
            default: begin
                if (ef >= 10'sd255) begin
                    flags[F_OF] = 1'b1;
                    flags[F_NX] = 1'b1;
                    if (rm == RM_RNE || (rm == RM_RUP && !s) ||
                        (rm == RM_RDN && s))
                        result = {s, 8'hff, 23'h0};
                    else
                        result = {s, 31'h7f7fffff};
                end else if (ef <= 10'sd0) begin
                    flags[F_UF] = 1'b1;
                    flags[F_NX] = 1'b1;
                    result      = {s, 31'h0};
                end else begin
                    flags[F_NX] = g | st;
                    result      = {s, ef[7:0], frac};
                end
            end
        endcase
    end

endmodule

// File: rtl/fdiv_pack.sv
// Divide unpack/pack stage: operand fractions out to the divider, side-band
// pipeline in lockstep with it, and the registered packed quotient.
import fpu_pkg::*;

module fdiv_pack (
    input  logic        clk,
    input  logic        clrn,
    input  logic        ena,
    input  logic [4:0]  count,
    input  logic [31:0] fa,
    input  logic [31:0] fb,
    input  logic [1:0]  rm,
    output logic [23:0] frac_a,
    output logic [23:0] frac_b,
    input  logic [31:0] q,
    output logic [31:0] result,
    output logic [4:0]  flags,
    output logic        valid
);

    sb_t         id;
    sb_t         e1;
    sb_t         e2;
    sb_t         e3;
    logic [31:0] r_res;
    logic [4:0]  r_flags;
    logic [9:0]  e_new;

    assign frac_a = {1'b1, fa[22:0]};
    assign frac_b = {1'b1, fb[22:0]};
    assign e_new  = {2'b00, fa[30:23]} - {2'b00, fb[30:23]} + 10'(BIAS - 1);

    fdiv_round u_round (
        .q      (q),
        .s      (e3.s),
        .e      ($signed(e3.e)),
        .rm     (e3.rm),
        .cls    (e3.sp.cls),
        .result (r_res),
        .flags  (r_flags)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            id     <= '0;
            e1     <= '0;
            e2     <= '0;
            e3     <= '0;
            result <= 32'h0;
            flags  <= 5'h0;
            valid  <= 1'b0;
        end else if (ena) begin
            if (count == 5'h01) begin
                id.s  <= fa[31] ^ fb[31];
                id.e  <= e_new;
                id.rm <= rm;
                id.sp <= classify(fa, fb);
            end
            id.tok <= count == 5'h10;
            e1     <= id;
            e2     <= e1;
            e3     <= e2;
            valid  <= e3.tok;
            if (e3.tok) begin
                result <= r_res;
                flags  <= r_flags |
                          {e3.sp.nv, e3.sp.dz, 3'b000};
            end
        end
    end

endmodule

// File: tb/tb_fdiv_pack.sv
// Directed bench for fdiv_pack: expected results queued at issue,
// compared by an independent monitor on each new valid output.
module tb_fdiv_pack;

    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] NV   = 5'b10000;
    localparam logic [4:0] DZ   = 5'b01000;
    localparam logic [4:0] OFX  = 5'b00101;
    localparam logic [4:0] UFX  = 5'b00011;
    localparam logic [4:0] NX   = 5'b00001;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        ena = 1'b1;
    logic [4:0]  count = 5'h0;
    logic [31:0] fa = 32'h0;
    logic [31:0] fb = 32'h0;
    logic [1:0]  rm = 2'b00;
    logic [23:0] frac_a;
    logic [23:0] frac_b;
    logic [31:0] q = 32'h0;
    logic [31:0] result;
    logic [4:0]  flags;
    logic        valid;

    int tests = 0;
    int fails = 0;
    logic [36:0] exp_q[$];
    logic        pv = 1'b0;

    fdiv_pack dut (
        .clk    (clk),
        .clrn   (clrn),
        .ena    (ena),
        .count  (count),
        .fa     (fa),
        .fb     (fb),
        .rm     (rm),
        .frac_a (frac_a),
        .frac_b (frac_b),
        .q      (q),
        .result (result),
        .flags  (flags),
        .valid  (valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid && !pv) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output result=%h flags=%b", result, flags);
            end else begin
                logic [36:0] x;
                x = exp_q.pop_front();
                if (result !== x[36:5] || flags !== x[4:0]) begin
                    fails++;
                    $display("FAIL result got=%h/%b want=%h/%b",
                             result, flags, x[36:5], x[4:0]);
                end
            end
        end
        pv = valid;
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] m, input logic [31:0] qq);
        fa = a;
        fb = b;
        rm = m;
        q  = qq;
        for (int c = 1; c <= 16; c++) begin
            count = 5'(c);
            tick();
        end
        count = 5'h0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL timeout pending=%0d", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] m, input logic [31:0] qq,
                           input logic [31:0] er, input logic [4:0] ef);
        exp_q.push_back({er, ef});
        issue(a, b, m, qq);
        repeat (3) tick();
        chk("valid_e3", 32'(valid), 32'd0);
        tick();
        chk("valid_w", 32'(valid), 32'd1);
        drain();
        repeat (2) tick();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_result", result, 32'h0);
        chk("rst_flags", 32'(flags), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        #1 clrn = 1'b1;
        tick();

        run_div(32'h40c00000, 32'h40000000, 2'b00, 32'hc0000000, 32'h40400000, NONE);
        chk("frac_a", 32'(frac_a), 32'h00c00000);
        chk("frac_b", 32'(frac_b), 32'h00800000);
        run_div(32'hc0c00000, 32'h40000000, 2'b00, 32'hc0000000, 32'hc0400000, NONE);
        run_div(32'h3f800000, 32'h40400000, 2'b00, 32'h55555555, 32'h3eaaaaab, NX);
        run_div(32'h3f800000, 32'h40400000, 2'b01, 32'h55555555, 32'h3eaaaaaa, NX);
        run_div(32'h3f800000, 32'h40400000, 2'b11, 32'h55555555, 32'h3eaaaaab, NX);
        run_div(32'h3f800000, 32'h40400000, 2'b10, 32'h55555555, 32'h3eaaaaaa, NX);
        run_div(32'h3f800000, 32'h3f800000, 2'b00, 32'h7fffffff, 32'h3f800000, NX);
        run_div(32'h3f800000, 32'h00000000, 2'b00, 32'h0, 32'h7f800000, DZ);
        run_div(32'h00000000, 32'h00000000, 2'b00, 32'h0, 32'h7fc00000, NV);
        run_div(32'h7f800001, 32'h3f800000, 2'b00, 32'h0, 32'h7fc00000, NV);
        run_div(32'h00400000, 32'h3f800000, 2'b00, 32'h0, 32'h00000000, NONE);
        run_div(32'h7f000000, 32'h3e800000, 2'b00, 32'h80000000, 32'h7f800000, OFX);
        run_div(32'h7f000000, 32'h3e800000, 2'b01, 32'h80000000, 32'h7f7fffff, OFX);
        run_div(32'hff000000, 32'h3e800000, 2'b11, 32'h80000000, 32'hff7fffff, OFX);
        run_div(32'hff000000, 32'h3e800000, 2'b10, 32'h80000000, 32'hff800000, OFX);
        run_div(32'h00800000, 32'h40000000, 2'b00, 32'h80000000, 32'h00000000, UFX);
        run_div(32'h80800000, 32'h40000000, 2'b00, 32'h80000000, 32'h80000000, UFX);

        fa = 32'h3f800000;
        fb = 32'h40400000;
        q  = 32'h55555555;
        for (int c = 1; c <= 8; c++) begin
            count = 5'(c);
            if (c < 8) tick();
        end
        clrn = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(valid), 32'h0);
        chk("midrst_result", result, 32'h0);
        count = 5'h0;
        tick();
        clrn = 1'b1;
        tick();
        run_div(32'h40c00000, 32'h40000000, 2'b00, 32'hc0000000, 32'h40400000, NONE);

        exp_q.push_back({32'h3eaaaaab, NX});
        issue(32'h3f800000, 32'h40400000, 2'b00, 32'h55555555);
        repeat (2) tick();
        ena = 1'b0;
        repeat (3) tick();
        chk("hold_valid", 32'(valid), 32'h0);
        chk("hold_result", result, 32'h40400000);
        ena = 1'b1;
        drain();
        repeat (2) tick();
        chk("final_result", result, 32'h3eaaaaab);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
